// File: rtl/dram_cache_pkg.sv
// Shared definitions for the direct-mapped, write-through DRAM cache:
// controller states, access-type encoding and default geometry.
package dram_cache_pkg;

  localparam int DEFAULT_INDEX_W = 10;
  localparam int DEFAULT_ADDR_W  = 27;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RD_MISS,
    WR_THRU,
    RESP
  } state_t;

endpackage

// File: rtl/dram_cache_array.sv
// Tag+data line storage: one synchronous read port, one write port, no reset,
// so synthesis can map it onto block RAM.
module cache_array
  import dram_cache_pkg::*;
#(
  parameter int INDEX_W = DEFAULT_INDEX_W,
  parameter int WIDTH   = DEFAULT_ADDR_W - DEFAULT_INDEX_W + 32
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [WIDTH-1:0]   rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0]   wr_data
);

  logic [WIDTH-1:0] mem [2**INDEX_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/dram_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with one 32-bit word per
// line, sitting between a core request port and a DRAM request port.
module dram_cache
  import dram_cache_pkg::*;
#(
  parameter int INDEX_W = DEFAULT_INDEX_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_core,
  input  logic [31:0]       din_core,
  input  logic              rw_core,
  input  logic              valid_core,
  input  logic              flush,
  output logic [31:0]       dout_core,
  output logic              ready_core,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic [31:0]       mem_dout,
  input  logic              mem_ready
);

  localparam int TAG_W  = ADDR_W - INDEX_W;
  localparam int LINE_W = TAG_W + 32;
  localparam int LINES  = 2**INDEX_W;

  state_t state, state_next;

  logic [LINES-1:0]   valid_bits;
  logic               flush_pending;
  logic [ADDR_W-1:0]  req_addr;
  logic [31:0]        req_din;
  logic               req_rw;
  logic               lookup_valid;
  logic               hit_q;
  logic [31:0]        dout_q;
  logic [LINE_W-1:0]  rd_line;
  logic [LINE_W-1:0]  wr_line_data;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic               flush_now;
  logic               accept;
  logic               hit;
  logic               fill;
  logic               wr_line;

  assign req_tag   = req_addr[ADDR_W-1:INDEX_W];
  assign req_idx   = req_addr[INDEX_W-1:0];
  // A pending or fresh flush wins over acceptance in IDLE; the core keeps
  // valid_core high, so the request is simply taken one cycle later.
  assign flush_now = (state == IDLE) && (flush || flush_pending);
  assign accept    = (state == IDLE) && valid_core && !flush_now;
  assign hit       = lookup_valid && (rd_line[LINE_W-1:32] == req_tag);
  assign fill      = (state == RD_MISS) && mem_ready;
  assign wr_line   = fill || ((state == WR_THRU) && mem_ready && hit_q);
  assign wr_line_data = fill ? {req_tag, mem_dout} : {req_tag, req_din};

  cache_array #(
    .INDEX_W (INDEX_W),
    .WIDTH   (LINE_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (accept),
    .rd_idx  (addr_core[INDEX_W-1:0]),
    .rd_data (rd_line),
    .wr_en   (wr_line),
    .wr_idx  (req_idx),
    .wr_data (wr_line_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_core = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = LOOKUP;
      LOOKUP: begin
        if (req_rw == RW_WRITE) begin
          state_next = WR_THRU;
        end else if (hit) begin
          ready_core = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RD_MISS;
        end
      end
      RD_MISS: if (mem_ready) state_next = RESP;
      WR_THRU: if (mem_ready) state_next = RESP;
      RESP: begin
        ready_core = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_valid = (state == RD_MISS) || (state == WR_THRU);
  assign mem_rw    = (state == WR_THRU);
  assign mem_addr  = req_addr;
  assign mem_din   = req_din;
  // A read hit answers straight from the array output during LOOKUP.
  assign dout_core = (state == LOOKUP) ? rd_line[31:0] : dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits    <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (flush_now) begin
        valid_bits    <= '0;
        flush_pending <= 1'b0;
      end else if ((state != IDLE) && flush) begin
        flush_pending <= 1'b1;
      end
      if (fill) valid_bits[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr     <= '0;
      req_din      <= '0;
      req_rw       <= RW_READ;
      lookup_valid <= 1'b0;
      hit_q        <= 1'b0;
      dout_q       <= '0;
    end else begin
      if (accept) begin
        req_addr     <= addr_core;
        req_din      <= din_core;
        req_rw       <= rw_core;
        lookup_valid <= valid_bits[addr_core[INDEX_W-1:0]];
      end
      if (state == LOOKUP) hit_q  <= hit;
      if (fill)            dout_q <= mem_dout;
    end
  end

endmodule

// File: doc/dram_cache.md
DRAM_CACHE -- requirements
Module: dram_cache

Interface
REQ-001 Parameter INDEX_W, default 10, SHALL set the line-index width (2^INDEX_W one-word lines).
REQ-002 Parameter ADDR_W, default 27, SHALL set the word-address width on both sides.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 addr_core  input  ADDR_W  SHALL carry the word address from the core (tag = addr[ADDR_W-1:INDEX_W], index = addr[INDEX_W-1:0]).
REQ-006 din_core  input  32  SHALL carry write data from the core.
REQ-007 rw_core  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-008 valid_core  input  1  SHALL be the request strobe, held with addr/din/rw stable until ready_core.
REQ-009 flush  input  1  SHALL be a pulse that invalidates all lines.
REQ-010 dout_core  output  32  SHALL carry read data, valid while ready_core=1.
REQ-011 ready_core  output  1  SHALL be a one-cycle completion pulse per request.
REQ-012 mem_addr / mem_din  output  ADDR_W / 32  SHALL carry the downstream DRAM address and write data.
REQ-013 mem_rw / mem_valid  output  1 / 1  SHALL carry the downstream access type (1 = write) and request strobe.
REQ-014 mem_dout / mem_ready  input  32 / 1  SHALL carry downstream read data and a one-cycle completion pulse.

Function
REQ-015 The policy SHALL be direct-mapped, write-through, no-write-allocate, with one 32-bit word per line.
REQ-016 FSM states SHALL be IDLE, LOOKUP, RD_MISS, WR_THRU, RESP.
REQ-017 IDLE: valid_core=1 and flush=0 SHALL latch the request, issue the tag/data/valid array reads, and go to LOOKUP.
REQ-018 LOOKUP, read hit (valid bit set and tag equal): the block SHALL drive ready_core=1 and dout_core=cached word in this cycle and return to IDLE, giving a 2-cycle latency from acceptance.
REQ-019 LOOKUP, read miss: the block SHALL go to RD_MISS.
REQ-020 LOOKUP, any write: the block SHALL go to WR_THRU.
REQ-021 RD_MISS: the block SHALL hold mem_valid=1, mem_rw=0, mem_addr=latched address until mem_ready.
REQ-022 On mem_ready in RD_MISS, the block SHALL write mem_dout, the tag and valid=1 into the line, capture mem_dout into dout_core, and go to RESP.
REQ-023 WR_THRU: the block SHALL hold mem_valid=1, mem_rw=1, mem_din=latched data until mem_ready.
REQ-024 On mem_ready in WR_THRU, the block SHALL overwrite the line's data only if LOOKUP was a hit, then go to RESP; a miss SHALL leave tag and valid untouched.
REQ-025 RESP: the block SHALL drive ready_core=1 for exactly one cycle, then go to IDLE.
REQ-026 mem_valid SHALL be high only in RD_MISS/WR_THRU and SHALL deassert in the cycle after mem_ready.
REQ-027 flush in IDLE SHALL clear all valid bits in one cycle and take priority over a simultaneous valid_core; that request SHALL be accepted the next cycle.
REQ-028 flush outside IDLE SHALL be registered as pending and applied on the IDLE entry, before any new acceptance.
REQ-029 A request whose tag equals an invalid line's stale tag SHALL miss.
REQ-030 Index wrap: address 2^INDEX_W SHALL alias index 0 with tag 1.
REQ-031 ready_core SHALL never be asserted without a preceding accepted valid_core.
REQ-032 The block SHALL ignore valid_core outside IDLE.

Reset
REQ-033 rst SHALL force state IDLE, all valid bits 0, flush-pending 0, and ready_core, mem_valid, mem_rw, dout_core, mem_addr, mem_din to 0.
REQ-034 Tag and data arrays SHALL NOT be reset, so they map to block RAM.
REQ-035 rst asserted mid-transaction SHALL abort it with no ready_core pulse; any mem_ready arriving after reset in IDLE SHALL be ignored.

Structure
REQ-036 The shared package SHALL hold the FSM state enumeration, the rw encoding constants (RW_READ=0, RW_WRITE=1), and the default INDEX_W/ADDR_W.
REQ-037 The tag+data storage SHALL be a single sub-module, cache_array: a synchronous-read, single-write-port RAM of width (ADDR_W-INDEX_W+32); valid bits SHALL stay as flops in dram_cache.

Verification
REQ-038 Cold read 0x000010, with mem_dout=0xDEADBEEF after 5 cycles: exactly one mem_valid read, ready_core with 0xDEADBEEF; a repeat read gives ready 2 cycles after valid with no mem_valid.
REQ-039 Write 0x000010 = 0x12345678 after that fill: mem write issued with mem_din=0x12345678; a following read hits and returns 0x12345678 with no mem read.
REQ-040 Write 0x000020 = 0xA5A5A5A5 to a never-read line, then read 0x000020: the write passes through, and the read misses and fetches from memory (no-write-allocate).
REQ-041 Aliasing: fill 0x000000, then read 0x000400 (INDEX_W=10): miss replaces the line; a read of 0x000000 misses again.
REQ-042 flush coincident with valid_core in IDLE: the request is accepted one cycle later; a previously cached address now misses.
REQ-043 rst pulsed during RD_MISS while mem_valid=1: mem_valid drops immediately, no ready_core, all lines read as misses afterwards.
